// File: rtl/prod_result_checker.sv
// ---------------------------------------------------------------------------
// prod_result_checker
//
// Purpose:
//   Result scoreboard for the 16x16 -> 32-bit signed multiply program. Once
//   the CPU reports done, it walks data memory through a byte read port,
//   pulls back each operand pair and its stored product, recomputes the
//   product and keeps pass/fail statistics so a run can check itself.
//
// Ports:
//   clk            - system clock, everything updates on the rising edge
//   reset          - synchronous active-high reset
//   start          - CPU start request (high = CPU held / restarting)
//   done           - CPU done acknowledge
//   rd_addr        - data-memory byte read address
//   rd_data        - data-memory read data, valid one cycle after rd_addr
//   check_busy     - a check run is in progress
//   check_done     - the last run completed, held until next run/abort/reset
//   pass_cnt       - matching pairs in the current/last run
//   fail_cnt       - mismatching pairs in the current/last run
//   first_fail_vld - a mismatch has been seen this run
//   first_fail_idx - pair index of the first mismatch
//   mismatch       - one-cycle pulse in the compare cycle of a failing pair
// ---------------------------------------------------------------------------
module prod_result_checker #(
   parameter int NUM_PAIRS = 16,
   parameter int OP_BASE   = 0,
   parameter int PROD_BASE = 64,
   parameter int AW        = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          done,
   output logic [AW-1:0] rd_addr,
   input  logic [7:0]    rd_data,
   output logic          check_busy,
   output logic          check_done,
   output logic [4:0]    pass_cnt,
   output logic [4:0]    fail_cnt,
   output logic          first_fail_vld,
   output logic [3:0]    first_fail_idx,
   output logic          mismatch
);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, CMP, DONE} state_t;

   localparam logic [3:0] LAST_K = 4'(NUM_PAIRS - 1);

   state_t        state_q, state_d;
   logic [3:0]    pairIdx_q, pairIdx_d;
   logic [2:0]    byteIdx_q, byteIdx_d;
   logic [63:0]   fetchBuf_q, fetchBuf_d;
   logic [AW-1:0] rdAddr_q, rdAddr_d;
   logic          doneSeen_q, doneSeen_d;
   logic          busy_q, busy_d;
   logic          checkDone_q, checkDone_d;
   logic [4:0]    passCnt_q, passCnt_d;
   logic [4:0]    failCnt_q, failCnt_d;
   logic          ffVld_q, ffVld_d;
   logic [3:0]    ffIdx_q, ffIdx_d;

   logic [15:0]   opA, opB;
   logic [31:0]   prodStored, aExt, bExt, prodExpected;
   logic          pairFails, trigger;

   // Byte address of byte b of pair k: bytes 0..3 are the two operands,
   // bytes 4..7 the product. Both regions are four bytes per pair.
   function automatic logic [AW-1:0] byteAddr(input logic [3:0] k, input logic [2:0] b);
      logic [AW-1:0] base;
      base = b[2] ? AW'(PROD_BASE) : AW'(OP_BASE);
      return base + AW'({k, 2'b00}) + AW'(b[1:0]);
   endfunction

   // Unpack the gathered bytes (first byte fetched lands in the top byte) and
   // recompute the product. The operands are sign-extended to 32 bits first,
   // so the low 32 bits of the product are exactly the signed 32-bit result,
   // including -32768 * -32768 = 0x4000_0000.
   always_comb begin
      opA          = fetchBuf_q[63:48];
      opB          = fetchBuf_q[47:32];
      prodStored   = fetchBuf_q[31:0];
      aExt         = {{16{opA[15]}}, opA};
      bExt         = {{16{opB[15]}}, opB};
      prodExpected = bExt * aExt;
      pairFails    = (prodExpected != prodStored);
      trigger      = done && !doneSeen_q && !start;
   end

   // Next-state logic. A run walks FETCH (8 address cycles) -> WAIT (last
   // byte arrives) -> CMP for each pair. Read data lags the address by one
   // cycle, so the byte addressed in FETCH cycle b is shifted in during
   // cycle b+1, and byte 7 during WAIT. start high at any point in a run
   // abandons it, keeping whatever partial counts were reached.
   always_comb begin
      state_d     = state_q;
      pairIdx_d   = pairIdx_q;
      byteIdx_d   = byteIdx_q;
      fetchBuf_d  = fetchBuf_q;
      rdAddr_d    = rdAddr_q;
      doneSeen_d  = done;
      busy_d      = busy_q;
      checkDone_d = checkDone_q;
      passCnt_d   = passCnt_q;
      failCnt_d   = failCnt_q;
      ffVld_d     = ffVld_q;
      ffIdx_d     = ffIdx_q;
      mismatch    = 1'b0;

      case (state_q)
         IDLE: begin
            if (trigger) begin
               state_d     = FETCH;
               pairIdx_d   = 4'd0;
               byteIdx_d   = 3'd0;
               rdAddr_d    = byteAddr(4'd0, 3'd0);
               busy_d      = 1'b1;
               checkDone_d = 1'b0;
               passCnt_d   = 5'd0;
               failCnt_d   = 5'd0;
               ffVld_d     = 1'b0;
               ffIdx_d     = 4'd0;
            end
         end

         FETCH: begin
            if (start) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               if (byteIdx_q != 3'd0) begin
                  fetchBuf_d = {fetchBuf_q[55:0], rd_data};
               end
               if (byteIdx_q == 3'd7) begin
                  state_d = WAIT;
               end else begin
                  byteIdx_d = byteIdx_q + 3'd1;
                  rdAddr_d  = byteAddr(pairIdx_q, byteIdx_q + 3'd1);
               end
            end
         end

         WAIT: begin
            if (start) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               fetchBuf_d = {fetchBuf_q[55:0], rd_data};
               state_d    = CMP;
            end
         end

         CMP: begin
            if (start) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               if (pairFails) begin
                  mismatch  = 1'b1;
                  failCnt_d = failCnt_q + 5'd1;
                  if (!ffVld_q) begin
                     ffVld_d = 1'b1;
                     ffIdx_d = pairIdx_q;
                  end
               end else begin
                  passCnt_d = passCnt_q + 5'd1;
               end
               if (pairIdx_q == LAST_K) begin
                  state_d     = DONE;
                  busy_d      = 1'b0;
                  checkDone_d = 1'b1;
               end else begin
                  state_d   = FETCH;
                  pairIdx_d = pairIdx_q + 4'd1;
                  byteIdx_d = 3'd0;
                  rdAddr_d  = byteAddr(pairIdx_q + 4'd1, 3'd0);
               end
            end
         end

         DONE: begin
            if (start) begin
               state_d     = IDLE;
               checkDone_d = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State register. Reset clears everything, including the done history,
   // so a done that is already high when reset releases counts as a new
   // rising edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         pairIdx_q   <= 4'd0;
         byteIdx_q   <= 3'd0;
         fetchBuf_q  <= 64'd0;
         rdAddr_q    <= '0;
         doneSeen_q  <= 1'b0;
         busy_q      <= 1'b0;
         checkDone_q <= 1'b0;
         passCnt_q   <= 5'd0;
         failCnt_q   <= 5'd0;
         ffVld_q     <= 1'b0;
         ffIdx_q     <= 4'd0;
      end else begin
         state_q     <= state_d;
         pairIdx_q   <= pairIdx_d;
         byteIdx_q   <= byteIdx_d;
         fetchBuf_q  <= fetchBuf_d;
         rdAddr_q    <= rdAddr_d;
         doneSeen_q  <= doneSeen_d;
         busy_q      <= busy_d;
         checkDone_q <= checkDone_d;
         passCnt_q   <= passCnt_d;
         failCnt_q   <= failCnt_d;
         ffVld_q     <= ffVld_d;
         ffIdx_q     <= ffIdx_d;
      end
   end

   assign rd_addr        = rdAddr_q;
   assign check_busy     = busy_q;
   assign check_done     = checkDone_q;
   assign pass_cnt       = passCnt_q;
   assign fail_cnt       = failCnt_q;
   assign first_fail_vld = ffVld_q;
   assign first_fail_idx = ffIdx_q;

endmodule

// File: tb/tb_prod_result_checker.sv
// ---------------------------------------------------------------------------
// tb_prod_result_checker
//
// Fills a byte-wide data memory with operand pairs and products (some
// deliberately corrupted), plays the CPU start/done handshake, and checks
// the checker's reports. Expected results come from plain integer
// multiplication of the operands the bench wrote.
// ---------------------------------------------------------------------------
module tb_prod_result_checker;

   localparam int NUM_PAIRS = 16;
   localparam int OP_BASE   = 0;
   localparam int PROD_BASE = 64;
   localparam int AW        = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          done;
   logic [AW-1:0] rdAddr;
   logic [7:0]    rdData;
   logic          checkBusy;
   logic          checkDone;
   logic [4:0]    passCnt;
   logic [4:0]    failCnt;
   logic          ffVld;
   logic [3:0]    ffIdx;
   logic          mismatch;

   logic [7:0]    mem [256];

   typedef struct {
      int pass;
      int fail;
      int ffv;
      int ffi;
   } runExp_t;

   runExp_t expQ[$];
   int      failQ[$];
   runExp_t lastExp;
   bit      runArmed = 1'b0;
   int      numCompared = 0;
   int      numMismatched = 0;

   prod_result_checker #(
      .NUM_PAIRS(NUM_PAIRS),
      .OP_BASE  (OP_BASE),
      .PROD_BASE(PROD_BASE),
      .AW       (AW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .done          (done),
      .rd_addr       (rdAddr),
      .rd_data       (rdData),
      .check_busy    (checkBusy),
      .check_done    (checkDone),
      .pass_cnt      (passCnt),
      .fail_cnt      (failCnt),
      .first_fail_vld(ffVld),
      .first_fail_idx(ffIdx),
      .mismatch      (mismatch)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Data memory read port: registered, one cycle of latency.
   always @(posedge clk) rdData <= mem[rdAddr];

   // Single comparison point: counts every check and reports failures.
   task automatic checkOutput(input string name, input int actual, input int expected);
      numCompared++;
      if (actual != expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Write one pair and its product into memory, big-endian.
   task automatic writePair(input int k, input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] p);
      mem[OP_BASE + 4*k + 0]   = a[15:8];
      mem[OP_BASE + 4*k + 1]   = a[7:0];
      mem[OP_BASE + 4*k + 2]   = b[15:8];
      mem[OP_BASE + 4*k + 3]   = b[7:0];
      mem[PROD_BASE + 4*k + 0] = p[31:24];
      mem[PROD_BASE + 4*k + 1] = p[23:16];
      mem[PROD_BASE + 4*k + 2] = p[15:8];
      mem[PROD_BASE + 4*k + 3] = p[7:0];
   endtask

   // Build a memory image and the expected outcome of checking it.
   // mode 0: all correct, pair 0 is 3 * -7
   // mode 1: all correct except the low bit of byte 87 (product 5)
   // mode 2: random operands, about one product in four corrupted
   // mode 3: corner operands in pairs 0..2, all correct
   task automatic applyStimulus(input int mode, input bit pushExp);
      runExp_t e;
      shortint a, b;
      int trueP;
      logic [31:0] stored;
      e = '{0, 0, 0, 0};
      for (int k = 0; k < NUM_PAIRS; k++) begin
         a = shortint'($urandom);
         b = shortint'($urandom);
         if (mode == 0 && k == 0) begin a = 3; b = -7; end
         if (mode == 3 && k == 0) begin a = -32768; b = -32768; end
         if (mode == 3 && k == 1) begin a = -32768; b = 32767; end
         if (mode == 3 && k == 2) begin a = 0; b = -1; end
         trueP  = int'(a) * int'(b);
         stored = trueP;
         if (mode == 1 && k == 5) stored[0] = ~stored[0];
         if (mode == 2 && $urandom_range(3) == 0) stored = stored ^ (32'h1 << $urandom_range(31));
         writePair(k, a, b, stored);
         if (stored != trueP) begin
            e.fail++;
            if (e.ffv == 0) begin
               e.ffv = 1;
               e.ffi = k;
            end
            if (pushExp) failQ.push_back(k);
         end else begin
            e.pass++;
         end
      end
      lastExp = e;
      if (pushExp) expQ.push_back(e);
   endtask

   // CPU handshake: restart pulse, then done rising. Returns right after the
   // trigger edge.
   task automatic triggerRun();
      @(negedge clk);
      start = 1'b1;
      done  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      runArmed = 1'b1;
      done     = 1'b1;
      @(posedge clk);
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      while (!checkDone && n < 10*NUM_PAIRS + 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("run completes in time", int'(checkDone), 1);
   endtask

   // Monitor: tracks cycles since the trigger edge and checks each
   // mismatch pulse and each run completion against the scoreboard.
   initial begin
      int cyc;
      int idx;
      bit prevBusy;
      bit prevDone;
      runExp_t e;
      cyc = 0;
      prevBusy = 1'b0;
      prevDone = 1'b0;
      forever begin
         @(negedge clk);
         if (checkBusy && !prevBusy) begin
            cyc = 0;
            checkOutput("run started only when armed", int'(runArmed), 1);
            runArmed = 1'b0;
         end else begin
            cyc++;
         end
         if (mismatch) begin
            if (failQ.size() == 0) begin
               checkOutput("unexpected mismatch pulse", 1, 0);
            end else begin
               idx = failQ.pop_front();
               checkOutput("mismatch pulse cycle", cyc, 10*idx + 9);
            end
         end
         if (checkDone && !prevDone) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected check_done", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("run latency", cyc, 10*NUM_PAIRS);
               checkOutput("busy low at done", int'(checkBusy), 0);
               checkOutput("pass_cnt", int'(passCnt), e.pass);
               checkOutput("fail_cnt", int'(failCnt), e.fail);
               checkOutput("first_fail_vld", int'(ffVld), e.ffv);
               if (e.ffv != 0) checkOutput("first_fail_idx", int'(ffIdx), e.ffi);
            end
         end
         prevBusy = checkBusy;
         prevDone = checkDone;
      end
   end

   // Main stimulus sequence.
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      reset = 1'b1;
      start = 1'b1;
      done  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset rd_addr", int'(rdAddr), 0);
      checkOutput("reset check_busy", int'(checkBusy), 0);
      checkOutput("reset check_done", int'(checkDone), 0);
      checkOutput("reset pass_cnt", int'(passCnt), 0);
      checkOutput("reset fail_cnt", int'(failCnt), 0);
      checkOutput("reset first_fail_vld", int'(ffVld), 0);
      checkOutput("reset mismatch", int'(mismatch), 0);
      reset = 1'b0;

      $display("[TB] all-correct run");
      applyStimulus(0, 1'b1);
      triggerRun();
      waitDone();

      $display("[TB] product 5 corrupted");
      applyStimulus(1, 1'b1);
      triggerRun();
      waitDone();

      $display("[TB] corner operands");
      applyStimulus(3, 1'b1);
      triggerRun();
      waitDone();

      $display("[TB] done held high after run");
      applyStimulus(2, 1'b1);
      triggerRun();
      waitDone();
      repeat (500) @(negedge clk);
      checkOutput("held done keeps check_done", int'(checkDone), 1);
      checkOutput("held done keeps pass_cnt", int'(passCnt), lastExp.pass);
      checkOutput("held done keeps fail_cnt", int'(failCnt), lastExp.fail);
      applyStimulus(0, 1'b1);
      triggerRun();
      @(negedge clk);
      checkOutput("new run clears pass_cnt", int'(passCnt), 0);
      checkOutput("new run clears fail_cnt", int'(failCnt), 0);
      checkOutput("new run clears check_done", int'(checkDone), 0);
      checkOutput("new run sets check_busy", int'(checkBusy), 1);
      waitDone();

      $display("[TB] abort at cycle 40");
      applyStimulus(0, 1'b0);
      triggerRun();
      repeat (40) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      checkOutput("abort check_busy", int'(checkBusy), 0);
      checkOutput("abort check_done", int'(checkDone), 0);
      checkOutput("abort pass_cnt", int'(passCnt), 4);
      checkOutput("abort fail_cnt", int'(failCnt), 0);
      start = 1'b0;
      done  = 1'b0;

      $display("[TB] reset at cycle 75");
      applyStimulus(0, 1'b0);
      triggerRun();
      repeat (75) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("mid-run reset rd_addr", int'(rdAddr), 0);
      checkOutput("mid-run reset check_busy", int'(checkBusy), 0);
      checkOutput("mid-run reset pass_cnt", int'(passCnt), 0);
      checkOutput("mid-run reset fail_cnt", int'(failCnt), 0);
      done = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(2, 1'b1);
      triggerRun();
      waitDone();

      $display("[TB] random runs");
      for (int r = 0; r < 4; r++) begin
         applyStimulus(2, 1'b1);
         triggerRun();
         waitDone();
      end

      done = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("scoreboard drained", expQ.size() + failQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
